// File: rtl/ddc_packetizer.sv
// Packs DDC samples into 32-bit words, buffers them in a FIFO and frames them as header + payload packets.
// Define PKT_TRAILER_EN to append an XOR check word (header ^ payload) carrying eop.
module ddc_packetizer #(
    parameter int FIFO_AW = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        din_valid,
    input  logic [1:0]  width_mode,
    input  logic [2:0]  cal_mode,
    input  logic [7:0]  package_len,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        sop,
    output logic        eop,
    output logic        overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

`ifdef PKT_TRAILER_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_PAY = 2'd2, ST_TRL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_PAY = 2'd2} state_t;
`endif

    logic [1:0]         r_lane;
    logic [1:0]         r_wid;
    logic [31:0]        r_acc;
    logic               r_ovf;
    logic [1:0]         w_wid;
    logic [1:0]         w_last_lane;
    logic [31:0]        w_word;
    logic               w_wr_req;

    logic [31:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_full;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [31:0]        w_head;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_dout;
    logic               r_valid;
    logic               r_sop;
    logic               r_eop;
    logic [8:0]         r_cnt;
    logic [7:0]         r_seq;
    logic [31:0]        w_dout_nxt;
    logic               w_valid_nxt;
    logic               w_sop_nxt;
    logic               w_eop_nxt;
    logic [8:0]         w_cnt_nxt;
    logic [7:0]         w_seq_nxt;
    logic [8:0]         w_eff_len;
    logic               w_start;
    logic               w_hs;
    logic [31:0]        w_hdr;
`ifdef PKT_TRAILER_EN
    logic [31:0]        r_xor;
    logic [31:0]        w_xor_nxt;
`endif

    // Lane placement: width is only taken from the input at the start of a word
    always_comb begin
        w_wid       = (r_lane == 2'd0) ? width_mode : r_wid;
        w_word      = (r_lane == 2'd0) ? 32'd0 : r_acc;
        w_last_lane = 2'd0;
        case (w_wid)
            2'b01: begin
                w_last_lane = 2'd1;
                if (r_lane[0]) begin
                    w_word[31:16] = din[15:0];
                end else begin
                    w_word[15:0] = din[15:0];
                end
            end
            2'b10: begin
                w_last_lane = 2'd3;
                case (r_lane)
                    2'd0:    w_word[7:0]   = din[7:0];
                    2'd1:    w_word[15:8]  = din[7:0];
                    2'd2:    w_word[23:16] = din[7:0];
                    default: w_word[31:24] = din[7:0];
                endcase
            end
            default: begin
                w_last_lane = 2'd0;
                w_word      = din;
            end
        endcase
        w_wr_req = din_valid && (r_lane == w_last_lane);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lane <= 2'd0;
            r_wid  <= 2'd0;
            r_acc  <= 32'd0;
        end else if (din_valid) begin
            r_wid <= w_wid;
            if (w_wr_req) begin
                r_lane <= 2'd0;
                r_acc  <= 32'd0;
            end else begin
                r_lane <= r_lane + 2'd1;
                r_acc  <= w_word;
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle read never rescues a write
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_wr_en = w_wr_req && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_wr_req && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {FIFO_AW{1'b0}};
            r_rd_ptr <= {FIFO_AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_eff_len = (package_len == 8'd0) ? 9'd256 : {1'b0, package_len};
    assign w_start   = (r_count >= CW'(w_eff_len));
    assign w_hs      = r_valid && dout_ready;
    assign w_hdr     = {8'hA5, r_seq, cal_mode, width_mode, 3'b000, package_len};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_start ? ST_HDR : ST_IDLE;
            ST_HDR:  w_state_nxt = w_hs ? ST_PAY : ST_HDR;
            ST_PAY: begin
                if (w_hs && (r_cnt == 9'd1)) begin
`ifdef PKT_TRAILER_EN
                    w_state_nxt = ST_TRL;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end else begin
                    w_state_nxt = ST_PAY;
                end
            end
`ifdef PKT_TRAILER_EN
            ST_TRL:  w_state_nxt = w_hs ? ST_IDLE : ST_TRL;
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next value of the output stage; the next word is loaded on the handshake that retires the current one
    always_comb begin
        w_dout_nxt  = r_dout;
        w_valid_nxt = r_valid;
        w_sop_nxt   = r_sop;
        w_eop_nxt   = r_eop;
        w_cnt_nxt   = r_cnt;
        w_seq_nxt   = r_seq;
        w_rd_en     = 1'b0;
`ifdef PKT_TRAILER_EN
        w_xor_nxt   = r_xor;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = w_eff_len;
                if (w_start) begin
                    w_dout_nxt  = w_hdr;
                    w_valid_nxt = 1'b1;
                    w_sop_nxt   = 1'b1;
                    w_eop_nxt   = 1'b0;
                end else begin
                    w_dout_nxt  = 32'd0;
                    w_valid_nxt = 1'b0;
                    w_sop_nxt   = 1'b0;
                    w_eop_nxt   = 1'b0;
                end
            end
            ST_HDR: begin
                if (w_hs) begin
                    w_dout_nxt = w_head;
                    w_rd_en    = 1'b1;
                    w_sop_nxt  = 1'b0;
`ifdef PKT_TRAILER_EN
                    w_eop_nxt  = 1'b0;
                    w_xor_nxt  = r_dout;
`else
                    w_eop_nxt  = (r_cnt == 9'd1);
`endif
                end else begin
                    w_dout_nxt = r_dout;
                end
            end
            ST_PAY: begin
                if (w_hs) begin
                    w_cnt_nxt = r_cnt - 9'd1;
`ifdef PKT_TRAILER_EN
                    w_xor_nxt = r_xor ^ r_dout;
`endif
                    if (r_cnt == 9'd1) begin
`ifdef PKT_TRAILER_EN
                        w_dout_nxt  = r_xor ^ r_dout;
                        w_eop_nxt   = 1'b1;
`else
                        w_dout_nxt  = 32'd0;
                        w_valid_nxt = 1'b0;
                        w_eop_nxt   = 1'b0;
                        w_seq_nxt   = r_seq + 8'd1;
`endif
                    end else begin
                        w_dout_nxt = w_head;
                        w_rd_en    = 1'b1;
`ifdef PKT_TRAILER_EN
                        w_eop_nxt  = 1'b0;
`else
                        w_eop_nxt  = (r_cnt == 9'd2);
`endif
                    end
                end else begin
                    w_dout_nxt = r_dout;
                end
            end
`ifdef PKT_TRAILER_EN
            ST_TRL: begin
                if (w_hs) begin
                    w_dout_nxt  = 32'd0;
                    w_valid_nxt = 1'b0;
                    w_eop_nxt   = 1'b0;
                    w_seq_nxt   = r_seq + 8'd1;
                end else begin
                    w_dout_nxt = r_dout;
                end
            end
`endif
            default: begin
                w_dout_nxt  = 32'd0;
                w_valid_nxt = 1'b0;
                w_sop_nxt   = 1'b0;
                w_eop_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout  <= 32'd0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_cnt   <= 9'd0;
            r_seq   <= 8'd0;
`ifdef PKT_TRAILER_EN
            r_xor   <= 32'd0;
`endif
        end else begin
            r_dout  <= w_dout_nxt;
            r_valid <= w_valid_nxt;
            r_sop   <= w_sop_nxt;
            r_eop   <= w_eop_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seq   <= w_seq_nxt;
`ifdef PKT_TRAILER_EN
            r_xor   <= w_xor_nxt;
`endif
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign sop        = r_sop;
    assign eop        = r_eop;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_ddc_packetizer.sv
// Bench for ddc_packetizer: a word-queue/packet model predicts every output beat, plus literal spot checks.
module tb_ddc_packetizer;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;
`ifdef PKT_TRAILER_EN
    localparam int TW = 1;
`else
    localparam int TW = 0;
`endif

    logic        clk, rst;
    logic [31:0] din;
    logic        din_valid;
    logic [1:0]  width_mode;
    logic [2:0]  cal_mode;
    logic [7:0]  package_len;
    logic [31:0] dout;
    logic        dout_valid, dout_ready, sop, eop, overflow;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] word_q[$];
    logic [31:0] log_q[$];
    logic [31:0] hdr_log[$];
    int          n_cmp, n_err, hs_count, ready_mode;
    int          m_idx, m_n;
    logic [31:0] m_acc;
    logic [7:0]  m_seq;
    logic        m_ovf;
    logic        prev_v, prev_r, prev_s, prev_e;
    logic [31:0] prev_d;

    ddc_packetizer #(.FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .width_mode(width_mode), .cal_mode(cal_mode), .package_len(package_len),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .sop(sop), .eop(eop), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] lg(input int idx);
        if (idx < log_q.size()) return log_q[idx];
        return 32'hDEADBEEF;
    endfunction

    task automatic model_clear();
        word_q.delete();
        exp_q.delete();
        m_idx = 0;
        m_n   = 1;
        m_acc = 32'd0;
        m_seq = 8'd0;
        m_ovf = 1'b0;
    endtask

    // Packing rule: samples per word fixed at word start, first sample in the low lane
    task automatic model_sample(input logic [31:0] d);
        int bits;
        logic [31:0] mask;
        if (m_idx == 0) begin
            m_n   = (width_mode == 2'b01) ? 2 : (width_mode == 2'b10) ? 4 : 1;
            m_acc = 32'd0;
        end
        bits  = 32 / m_n;
        mask  = (bits == 32) ? 32'hFFFFFFFF : ((32'd1 << bits) - 32'd1);
        m_acc = m_acc | ((d & mask) << (bits * m_idx));
        m_idx++;
        if (m_idx == m_n) begin
            m_idx = 0;
            if (word_q.size() >= DEPTH) m_ovf = 1'b1;
            else word_q.push_back(m_acc);
        end
    endtask

    task automatic build_packet();
        int n;
        logic [31:0] h, x, w;
        n = (package_len == 8'd0) ? 256 : int'(package_len);
        if (word_q.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL model_underrun: got %0d words, expected %0d", word_q.size(), n);
            return;
        end
        h = {8'hA5, m_seq, cal_mode, width_mode, 3'b000, package_len};
        hdr_log.push_back(h);
        exp_q.push_back('{d: h, s: 1'b1, e: 1'b0});
        x = h;
        for (int i = 0; i < n; i++) begin
            w = word_q.pop_front();
            x = x ^ w;
            exp_q.push_back('{d: w, s: 1'b0, e: (i == n - 1) && (TW == 0)});
        end
        if (TW == 1) exp_q.push_back('{d: x, s: 1'b0, e: 1'b1});
        m_seq = m_seq + 8'd1;
    endtask

    // Single compare process: stall stability, bubble/gap rules and every handshaked beat
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("stall_valid", dout_valid, 1'b1);
                chk("stall_dout", dout, prev_d);
                chk("stall_sop", sop, prev_s);
                chk("stall_eop", eop, prev_e);
            end
            if (prev_v && prev_r) chk(prev_e ? "idle_gap" : "no_bubble", dout_valid, !prev_e);
            if (dout_valid && dout_ready) begin
                beat_t b;
                if (exp_q.size() == 0) build_packet();
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    chk("beat_data", dout, b.d);
                    chk("beat_sop", sop, b.s);
                    chk("beat_eop", eop, b.e);
                end
                log_q.push_back(dout);
                hs_count++;
            end
            prev_v = dout_valid;
            prev_r = dout_ready;
            prev_d = dout;
            prev_s = sop;
            prev_e = eop;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d);
        din       = d;
        din_valid = 1'b1;
        model_sample(d);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && word_q.size() == 0 && dout_valid == 1'b0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(t >= budget), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] wm, input logic [2:0] cm, input logic [7:0] pl);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_dout", dout, 32'd0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_sop", sop, 1'b0);
        chk("rst_eop", eop, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        width_mode  = wm;
        cal_mode    = cm;
        package_len = pl;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, hb, t;
        logic [31:0] h;
        n_cmp = 0; n_err = 0; hs_count = 0; ready_mode = 0;
        rst = 1'b0; din = 32'd0; din_valid = 1'b0;
        width_mode = 2'b00; cal_mode = 3'd0; package_len = 8'd0;
        prev_v = 1'b0; prev_r = 1'b0; prev_s = 1'b0; prev_e = 1'b0; prev_d = 32'd0;
        model_clear();
        idle(2);
        do_reset(2'b00, 3'd3, 8'd4);

        // width 32, len 4, cal 3
        base = log_q.size();
        for (int k = 1; k <= 4; k++) send(32'(k));
        wait_drain(200, "drain_t1");
        chk("t1_hdr", lg(base), 32'hA5006004);
        for (int k = 1; k <= 4; k++) chk("t1_pay", lg(base + k), 32'(k));
        if (TW == 1) chk("t1_trailer", lg(base + 5), 32'hA5006000);

        // width 16 then width 8 packing
        width_mode = 2'b01; cal_mode = 3'd0; package_len = 8'd2;
        base = log_q.size();
        send(32'h1111); send(32'h2222); send(32'h3333); send(32'h4444);
        wait_drain(200, "drain_t2a");
        chk("t2_hdr", lg(base), 32'hA5010802);
        chk("t2_w0", lg(base + 1), 32'h22221111);
        chk("t2_w1", lg(base + 2), 32'h44443333);
        width_mode = 2'b10; package_len = 8'd1;
        base = log_q.size();
        for (int k = 1; k <= 4; k++) send(32'(k));
        wait_drain(200, "drain_t2b");
        chk("t2_hdr8", lg(base), 32'hA5021001);
        chk("t2_w8", lg(base + 1), 32'h04030201);

        // width change in the middle of a word only applies to the next word
        width_mode = 2'b01;
        base = log_q.size();
        send(32'hFFFF_AAAA);
        width_mode = 2'b10;
        send(32'h0000_BBBB);
        send(32'h11); send(32'h22); send(32'h33); send(32'h44);
        wait_drain(200, "drain_t3");
        chk("t3_mid_word", lg(base + 1), 32'hBBBBAAAA);
        chk("t3_next_word", lg(base + 3 + TW), 32'h44332211);

        // random ready
        width_mode = 2'b00; cal_mode = 3'd5; package_len = 8'd3;
        ready_mode = 1;
        for (int k = 0; k < 12; k++) begin
            send(32'h100 + 32'(k));
            if (k % 4 == 3) idle(2);
        end
        wait_drain(600, "drain_rand");
        ready_mode = 0;
        idle(2);

        // len 0: 257 packets of 256 words, seq wraps
        do_reset(2'b00, 3'd2, 8'd0);
        hb = hdr_log.size();
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < 256; i++) send(32'(p * 256 + i));
            idle(3);
        end
        wait_drain(2000, "drain_len0");
        chk("len0_pkts", 32'(hdr_log.size() - hb), 32'd257);
        h = (hb + 255 < hdr_log.size()) ? hdr_log[hb + 255] : 32'hDEADBEEF;
        chk("seq_255", {24'd0, h[23:16]}, 32'd255);
        h = (hb + 256 < hdr_log.size()) ? hdr_log[hb + 256] : 32'hDEADBEEF;
        chk("seq_wrap", {24'd0, h[23:16]}, 32'd0);
        chk("len0_no_ovf", overflow, 1'b0);

        // overflow with ready held low
        ready_mode = 2;
        cal_mode = 3'd4; package_len = 8'd0; width_mode = 2'b00;
        idle(2);
        for (int k = 0; k < DEPTH; k++) send(32'h5000_0000 + 32'(k));
        idle(3);
        chk("ovf_at_full", overflow, 1'b0);
        chk("ovf_model_full", overflow, m_ovf);
        send(32'h5000_0000 + 32'(DEPTH));
        idle(3);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_model_set", overflow, m_ovf);
        cal_mode = 3'd7; package_len = 8'd5;
        idle(5);
        cal_mode = 3'd4; package_len = 8'd0;
        ready_mode = 0;
        wait_drain(1500, "drain_ovf");
        chk("ovf_sticky", overflow, 1'b1);

        // reset in the middle of a payload, with a partial 16-bit word pending
        width_mode = 2'b01; cal_mode = 3'd1; package_len = 8'd4;
        base = hs_count;
        for (int k = 0; k < 9; k++) send(32'h7700 + 32'(k));
        t = 0;
        while (hs_count < base + 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_pay_reached", 32'(t >= 100), 32'd0);
        @(posedge clk);
        #1;
        do_reset(2'b00, 3'd6, 8'd5);
        base = log_q.size();
        for (int k = 7; k <= 11; k++) send(32'(k));
        wait_drain(200, "drain_rst");
        chk("rst_hdr", lg(base), 32'hA500C005);
        chk("rst_first", lg(base + 1), 32'd7);
        chk("rst_last", lg(base + 5), 32'd11);
        if (TW == 1) chk("rst_trailer", lg(base + 6), 32'hA500C002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
